// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit encodings, port indices, FSM states and field offsets
package noc_pkg;

    // Flit type field encodings (top two bits of a flit)
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    // Output port indices
    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_S = 2;
    localparam int PORT_E = 3;
    localparam int PORT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    // LSB of the two-bit type field
    function automatic int type_lsb(input int dw);
        return dw - 2;
    endfunction

    // MSB of the destination X field in a head flit
    function automatic int dst_x_msb(input int dw);
        return dw - 3;
    endfunction

    // MSB of the destination Y field in a head flit
    function automatic int dst_y_msb(input int dw, input int xw);
        return dw - 3 - xw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock flit FIFO with wrap-bit pointers
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   wr_en     : write request, ignored while full
//   wr_data   : data written on wr_en
//   rd_en     : pop request, ignored while empty
//   rd_data   : current head entry (combinational from storage)
//   full      : no free slot this cycle
//   empty     : no valid entry this cycle
module sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_wr;
    logic w_rd;

    // Extra MSB distinguishes full from empty when the low bits match
    assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty   = (r_wptr == r_rptr);
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign rd_data = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only observable through the pointers
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/vc_input_requester.sv
// rtl/vc_input_requester.sv - router input port: flit buffer, XY route, request/grant, wormhole send
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : upstream flit valid
//   in_data    : upstream flit
//   in_ready   : FIFO can accept a flit this cycle
//   request    : one-hot request to the output arbiters (held until granted)
//   grant      : grant bit for this port from each output arbiter
//   busy       : one-hot output owned by this port for the current packet
//   out_valid  : flit to crossbar valid
//   out_data   : flit to crossbar (FIFO head)
//   out_ready  : selected output accepts the flit
//   err        : one-cycle pulse per orphan body/tail flit dropped
module vc_input_requester
    import noc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int XW    = 4,
    parameter int DEPTH = 4,
    parameter int CUR_X = 0,
    parameter int CUR_Y = 0,
    parameter int NPORT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic [NPORT-1:0] request,
    input  logic [NPORT-1:0] grant,
    output logic [NPORT-1:0] busy,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready,
    output logic             err
);

    localparam int          T_LSB = type_lsb(DW);
    localparam int          X_MSB = dst_x_msb(DW);
    localparam int          Y_MSB = dst_y_msb(DW, XW);
    localparam logic [XW-1:0] CX  = CUR_X[XW-1:0];
    localparam logic [XW-1:0] CY  = CUR_Y[XW-1:0];

    state_t           r_state;
    state_t           w_next;
    logic [NPORT-1:0] r_sel;

    logic             w_full;
    logic             w_empty;
    logic [DW-1:0]    w_head;
    logic             w_pop;
    logic [1:0]       w_type;
    logic [XW-1:0]    w_dst_x;
    logic [XW-1:0]    w_dst_y;
    logic [NPORT-1:0] w_route_oh;
    logic             w_is_head;
    logic             w_is_last;
    logic             w_granted;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign in_ready  = !w_full;
    assign out_data  = w_head;

    assign w_type    = w_head[T_LSB +: 2];
    assign w_dst_x   = w_head[X_MSB -: XW];
    assign w_dst_y   = w_head[Y_MSB -: XW];
    assign w_is_head = (w_type == FLIT_HEAD) || (w_type == FLIT_SINGLE);
    assign w_is_last = (w_type == FLIT_TAIL) || (w_type == FLIT_SINGLE);

    // Dimension-ordered XY route: resolve X first, then Y, else deliver locally
    always_comb begin
        w_route_oh = '0;
        if (w_dst_x > CX)      w_route_oh[PORT_E] = 1'b1;
        else if (w_dst_x < CX) w_route_oh[PORT_W] = 1'b1;
        else if (w_dst_y > CY) w_route_oh[PORT_N] = 1'b1;
        else if (w_dst_y < CY) w_route_oh[PORT_S] = 1'b1;
        else                   w_route_oh[PORT_L] = 1'b1;
    end

    // Grant bits for outputs we did not request are ignored
    assign w_granted = |(grant & request);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == REQ && w_granted) r_sel <= w_route_oh;
        end
    end

    always_comb begin
        w_next    = r_state;
        request   = '0;
        busy      = '0;
        out_valid = 1'b0;
        w_pop     = 1'b0;
        err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (w_is_head) begin
                        w_next = REQ;
                    end else begin
                        // Body/tail with no owning packet: discard it
                        w_pop = 1'b1;
                        err   = 1'b1;
                    end
                end
            end
            REQ: begin
                // Head stays at the FIFO front, so the route is stable while requesting
                request = w_route_oh;
                if (w_granted) w_next = SEND;
            end
            SEND: begin
                busy      = r_sel;
                out_valid = !w_empty;
                if (out_valid && out_ready) begin
                    w_pop = 1'b1;
                    if (w_is_last) w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
